lcd_frame_lock_ctrl: RTL and testbench

Sequencing controller for the HP54542C LCD-to-VGA path. Samples the LCD line-sync input in the pixel-clock domain and classifies each sync edge as a line start or a frame start. Verifies that frames carry the expected line count, then holds the downstream VGA timing generator in reset until lock is achieved and releases it on a verified frame boundary. Runs a lock/holdover/relock state machine so that a glitching or unplugged LCD source never drives garbage timing to the monitor.

---
 rtl/lcd_frame_lock_ctrl_pkg.sv | 48 ++++
 rtl/lcd_frame_lock_ctrl_sync_edge_detect.sv | 44 ++++
 rtl/lcd_frame_lock_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_lcd_frame_lock_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_frame_lock_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_frame_lock_ctrl_pkg
// Description : Shared definitions for the HP54542C LCD-to-VGA path.
//               Holds the lock-controller state encoding, counter widths,
//               the VGA 640x480 timing constants used by the downstream
//               timing generator, and a small saturating-increment helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_frame_lock_ctrl_pkg;

  // Lock controller states
  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCKED = 2'd2
  } lock_state_t;

  // Counter widths
  localparam int c_gap_w  = 19;
  localparam int c_line_w = 10;
  localparam int c_idx_w  = 9;
  localparam int c_err_w  = 8;

  // VGA 640x480 @ 60 Hz timing, shared with the timing generator
  localparam int c_vga_h_active = 640;
  localparam int c_vga_h_fporch = 16;
  localparam int c_vga_h_sync   = 96;
  localparam int c_vga_h_bporch = 48;
  localparam int c_vga_h_total  = c_vga_h_active + c_vga_h_fporch +
                                  c_vga_h_sync + c_vga_h_bporch;
  localparam int c_vga_v_active = 480;
  localparam int c_vga_v_fporch = 10;
  localparam int c_vga_v_sync   = 2;
  localparam int c_vga_v_bporch = 33;
  localparam int c_vga_v_total  = c_vga_v_active + c_vga_v_fporch +
                                  c_vga_v_sync + c_vga_v_bporch;

  // Line counter increment that sticks at all-ones
  function automatic logic [c_line_w-1:0] line_cnt_inc(
    input logic [c_line_w-1:0] cnt
  );
    return (&cnt) ? cnt : cnt + c_line_w'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_frame_lock_ctrl_sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : lcd_frame_lock_ctrl_sync_edge_detect
// Description : sync_edge_detect block. Two-flop synchronizer for an
//               asynchronous input followed by a registered rising-edge
//               detector. Usable for any asynchronous LCD control input.
//               The pulse is high for one clock, two clocks after the first
//               clock edge that samples the input high.
// Ports       : iw_clk    - clock
//               iw_rst_n  - synchronous active-low reset
//               iw_async  - asynchronous input
//               ow_pulse  - one-cycle rising-edge pulse (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_frame_lock_ctrl_sync_edge_detect (
  input  logic iw_clk,
  input  logic iw_rst_n,
  input  logic iw_async,
  output logic ow_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;
  logic r_pulse;

  always_ff @(posedge iw_clk) begin
    if (!iw_rst_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
      r_pulse  <= 1'b0;
    end else begin
      r_meta   <= iw_async;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
      r_pulse  <= r_sync & ~r_sync_d;
    end
  end

  assign ow_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/lcd_frame_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lcd_frame_lock_ctrl
// Description : LCD frame lock controller. Classifies synchronized LCD
//               line-sync edges as line or frame starts by the idle gap
//               before them, checks each frame's line count, and runs a
//               SEARCH / VERIFY / LOCKED state machine. The VGA timing
//               generator is held in reset until lock, and released on a
//               verified frame boundary.
// Ports       : iw_clk          - pixel clock
//               iw_rst_n        - synchronous active-low reset
//               iw_sync         - raw LCD line sync (asynchronous)
//               ow_locked       - high while locked
//               ow_gen_rst      - holds the VGA timing generator in reset
//               ow_frame_start  - frame-start pulse while locked
//               ow_line_start   - line-start pulse while locked
//               ow_line_idx     - line index within the frame
//               ow_err_cnt      - saturating count of lock-loss events
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_frame_lock_ctrl
  import lcd_frame_lock_ctrl_pkg::*;
#(
  parameter int p_vpixels_active = 480,
  parameter int p_gap_min        = 1000,
  parameter int p_frame_timeout  = 450000,
  parameter int p_max_errs       = 2
) (
  input  logic               iw_clk,
  input  logic               iw_rst_n,
  input  logic               iw_sync,
  output logic               ow_locked,
  output logic               ow_gen_rst,
  output logic               ow_frame_start,
  output logic               ow_line_start,
  output logic [c_idx_w-1:0] ow_line_idx,
  output logic [c_err_w-1:0] ow_err_cnt
);

  localparam logic [c_gap_w-1:0]  c_gap_min    = c_gap_w'(p_gap_min);
  localparam logic [c_gap_w-1:0]  c_timeout    = c_gap_w'(p_frame_timeout);
  localparam logic [c_gap_w-1:0]  c_timeout_m1 = c_gap_w'(p_frame_timeout - 1);
  localparam logic [c_line_w-1:0] c_good_lines = c_line_w'(p_vpixels_active - 1);
  localparam logic [c_line_w-1:0] c_idx_lim    = c_line_w'((1 << c_idx_w) - 1);
  localparam logic [c_err_w-1:0]  c_max_errs   = c_err_w'(p_max_errs);

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic w_edge;

  lcd_frame_lock_ctrl_sync_edge_detect u_sync_edge (
    .iw_clk   (iw_clk),
    .iw_rst_n (iw_rst_n),
    .iw_async (iw_sync),
    .ow_pulse (w_edge)
  );

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  lock_state_t         r_state;
  logic [c_gap_w-1:0]  r_gap;
  logic [c_line_w-1:0] r_line_cnt;
  logic [c_err_w-1:0]  r_bad_cnt;
  logic [c_err_w-1:0]  r_err_cnt;
  logic                r_locked;
  logic                r_gen_rst;
  logic                r_frame_start;
  logic                r_line_start;
  logic [c_idx_w-1:0]  r_line_idx;

  // --------------------------------------------------------------------------
  // Edge classification and timeout
  // --------------------------------------------------------------------------
  logic w_frame_edge;
  logic w_line_edge;
  logic w_timeout;
  logic w_good_frame;

  assign w_frame_edge = w_edge && (r_gap > c_gap_min);
  assign w_line_edge  = w_edge && !w_frame_edge;
  // An edge arriving in the cycle the counter would hit the limit wins.
  assign w_timeout    = !w_edge && (r_gap == c_timeout_m1);
  assign w_good_frame = (r_line_cnt == c_good_lines);

  // --------------------------------------------------------------------------
  // Line counter next value and the index presented downstream
  // --------------------------------------------------------------------------
  logic [c_line_w-1:0] w_line_nxt;
  logic [c_idx_w-1:0]  w_idx_nxt;

  always_comb begin
    w_line_nxt = r_line_cnt;
    if (w_frame_edge) begin
      w_line_nxt = '0;
    end else if (w_line_edge) begin
      w_line_nxt = line_cnt_inc(r_line_cnt);
    end
  end

  // The index port is narrower than the counter; clamp rather than wrap.
  assign w_idx_nxt = (w_line_nxt > c_idx_lim) ? '1 : w_line_nxt[c_idx_w-1:0];

  // --------------------------------------------------------------------------
  // Lock state machine: next state and bookkeeping
  // --------------------------------------------------------------------------
  lock_state_t        w_state_nxt;
  logic [c_err_w-1:0] w_bad_nxt;
  logic [c_err_w-1:0] w_bad_inc;
  logic               w_err_inc;
  logic               w_lock_nxt;

  assign w_bad_inc = r_bad_cnt + c_err_w'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_bad_nxt   = r_bad_cnt;
    w_err_inc   = 1'b0;
    case (r_state)
      S_SEARCH: begin
        w_bad_nxt = '0;
        if (w_frame_edge) begin
          w_state_nxt = S_VERIFY;
        end
      end
      S_VERIFY: begin
        w_bad_nxt = '0;
        if (w_timeout) begin
          w_state_nxt = S_SEARCH;
        end else if (w_frame_edge && w_good_frame) begin
          w_state_nxt = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (w_timeout) begin
          w_state_nxt = S_SEARCH;
          w_bad_nxt   = '0;
          w_err_inc   = 1'b1;
        end else if (w_frame_edge) begin
          if (w_good_frame) begin
            w_bad_nxt = '0;
          end else if (w_bad_inc >= c_max_errs) begin
            w_state_nxt = S_SEARCH;
            w_bad_nxt   = '0;
            w_err_inc   = 1'b1;
          end else begin
            w_bad_nxt = w_bad_inc;
          end
        end
      end
      default: begin
        w_state_nxt = S_SEARCH;
        w_bad_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so that lock gain and lock loss
  // take effect in the cycle right after the deciding edge; this also makes
  // the generator-reset release coincide with the first frame_start pulse.
  assign w_lock_nxt = (w_state_nxt == S_LOCKED);

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge iw_clk) begin
    if (!iw_rst_n) begin
      r_state       <= S_SEARCH;
      r_gap         <= '0;
      r_line_cnt    <= '0;
      r_bad_cnt     <= '0;
      r_err_cnt     <= '0;
      r_locked      <= 1'b0;
      r_gen_rst     <= 1'b1;
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
      r_line_idx    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_line_cnt <= w_line_nxt;
      r_bad_cnt  <= w_bad_nxt;

      if (w_edge) begin
        r_gap <= '0;
      end else if (r_gap < c_timeout) begin
        r_gap <= r_gap + c_gap_w'(1);
      end

      if (w_err_inc && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + c_err_w'(1);
      end

      r_locked      <= w_lock_nxt;
      r_gen_rst     <= !w_lock_nxt;
      r_line_start  <= w_lock_nxt && w_edge;
      r_frame_start <= w_lock_nxt && w_frame_edge;
      r_line_idx    <= w_lock_nxt ? w_idx_nxt : '0;
    end
  end

  assign ow_locked      = r_locked;
  assign ow_gen_rst     = r_gen_rst;
  assign ow_frame_start = r_frame_start;
  assign ow_line_start  = r_line_start;
  assign ow_line_idx    = r_line_idx;
  assign ow_err_cnt     = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lcd_frame_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_frame_lock_ctrl
// Description : Self-checking bench for lcd_frame_lock_ctrl. Timing
//               parameters are scaled down (8 lines per frame, short gaps)
//               so whole frames fit in a short run. A frame-level reference
//               model decides, per sync edge and per timeout, what the
//               outputs must show four clocks after the sync pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_frame_lock_ctrl;

  localparam int V    = 8;    // active lines per frame
  localparam int GMIN = 20;   // gap above which an edge is a frame start
  localparam int TMO  = 300;  // idle clocks to lock loss
  localparam int MAXE = 2;    // consecutive bad frames tolerated

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sync;
  logic       locked;
  logic       gen_rst;
  logic       frame_start;
  logic       line_start;
  logic [8:0] line_idx;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  lcd_frame_lock_ctrl #(
    .p_vpixels_active (V),
    .p_gap_min        (GMIN),
    .p_frame_timeout  (TMO),
    .p_max_errs       (MAXE)
  ) dut (
    .iw_clk         (clk),
    .iw_rst_n       (rst_n),
    .iw_sync        (sync),
    .ow_locked      (locked),
    .ow_gen_rst     (gen_rst),
    .ow_frame_start (frame_start),
    .ow_line_start  (line_start),
    .ow_line_idx    (line_idx),
    .ow_err_cnt     (err_cnt)
  );

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: have we seen a frame start, are we locked, how many
  // consecutive bad frames, lines since the last frame start, lock losses.
  bit m_seen;
  bit m_locked;
  int m_bad;
  int m_lines;
  int m_errs;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_locked",      locked,      0);
    check("rst_gen_rst",     gen_rst,     1);
    check("rst_frame_start", frame_start, 0);
    check("rst_line_start",  line_start,  0);
    check("rst_line_idx",    line_idx,    0);
    check("rst_err_cnt",     err_cnt,     0);
    rst_n    = 1'b1;
    m_seen   = 0;
    m_locked = 0;
    m_bad    = 0;
    m_lines  = 0;
    m_errs   = 0;
  endtask

  // Produce one sync edge whose idle gap (clocks between consecutive edge
  // pulses, exclusive) is g. The previous call already spent 3 clocks of the
  // gap on its own latency check, hence g-3 idle clocks here. Only gaps below
  // TMO or at least TMO+3 are used so a timeout always lands in the idle loop.
  task automatic send_edge(input int g);
    bit is_frame;
    bit good;
    int eff;
    for (int j = 1; j <= g - 3; j++) begin
      @(posedge clk); #1;
      if (j == TMO - 1) check("pre_timeout_locked", locked, m_locked);
      if (j == TMO) begin
        if (m_locked && m_errs < 255) m_errs++;
        m_locked = 0;
        m_seen   = 0;
        m_bad    = 0;
        check("timeout_locked",   locked,   m_locked);
        check("timeout_gen_rst",  gen_rst,  !m_locked);
        check("timeout_err_cnt",  err_cnt,  m_errs);
        check("timeout_line_idx", line_idx, 0);
      end
    end
    sync = 1'b1;
    @(posedge clk); #1;
    sync = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("early_line_start", line_start, 0);
    @(posedge clk); #1;

    eff      = (g >= TMO) ? TMO : g;
    is_frame = (eff > GMIN);
    if (is_frame) begin
      good = (m_lines == V - 1);
      if (m_locked) begin
        if (good) begin
          m_bad = 0;
        end else begin
          m_bad++;
          if (m_bad >= MAXE) begin
            m_locked = 0;
            m_seen   = 0;
            m_bad    = 0;
            if (m_errs < 255) m_errs++;
          end
        end
      end else if (m_seen) begin
        if (good) m_locked = 1;
      end else begin
        m_seen = 1;
      end
      m_lines = 0;
    end else if (m_lines < 1023) begin
      m_lines++;
    end

    check("line_start",  line_start,  m_locked);
    check("frame_start", frame_start, m_locked && is_frame);
    check("line_idx",    line_idx,    m_locked ? m_lines : 0);
    check("locked",      locked,      m_locked);
    check("gen_rst",     gen_rst,     !m_locked);
    check("err_cnt",     err_cnt,     m_errs);
  endtask

  function automatic int line_gap();
    return ($urandom_range(4, 0) == 0) ? GMIN : $urandom_range(GMIN, 3);
  endfunction

  function automatic int frame_gap();
    return GMIN + 1 + $urandom_range(40, 0);
  endfunction

  // A frame of n edges: one frame-start edge after gap fg, then n-1 lines.
  task automatic send_frame(input int n, input int fg);
    send_edge(fg);
    for (int i = 1; i < n; i++) send_edge(line_gap());
  endtask

  initial begin
    int r;
    int n;
    int fg;
    rst_n = 1'b0;
    sync  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // Clean source: lock at the second frame start
    for (int k = 0; k < 4; k++) send_frame(V, frame_gap());

    // Classification boundary: gap GMIN+1 is a frame, gap GMIN is a line
    send_edge(GMIN + 1);
    for (int i = 1; i < V; i++) send_edge(GMIN);

    // One short frame is tolerated, a second consecutive one drops lock
    send_frame(V - 1, frame_gap());
    send_frame(3, frame_gap());
    for (int k = 0; k < 4; k++) send_frame(V, frame_gap());

    // Edge coinciding with the timeout limit keeps lock
    send_frame(V, TMO - 1);
    send_frame(V, frame_gap());

    // Source removed, then restored
    send_frame(V, TMO + 40);
    for (int k = 0; k < 3; k++) send_frame(V, frame_gap());

    // Reset in the middle of a locked frame, then reacquire
    send_edge(frame_gap());
    for (int i = 1; i < V / 2; i++) send_edge(line_gap());
    do_reset();
    for (int k = 0; k < 4; k++) send_frame(V, frame_gap());

    // Randomized frames: mostly clean, some wrong line counts and dropouts
    for (int k = 0; k < 30; k++) begin
      r  = $urandom_range(9, 0);
      n  = V;
      fg = frame_gap();
      if (r == 6)      n = V - 1;
      else if (r == 7) n = V + 1;
      else if (r == 8) n = $urandom_range(V + 3, 1);
      else if (r == 9) fg = TMO + 3 + $urandom_range(20, 0);
      send_frame(n, fg);
    end
    send_edge(frame_gap());

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
